// File: rtl/image_pkg.sv
// ---------------------------------------------------------------------------
// image_pkg
//   Shared constants and types for the 3x3 window line-buffer pipeline.
//   LINE_DEPTH : words per line slot in the 4-line buffer
//   PIX_W      : pixel width
//   WIN_W      : width of one window row (3 pixels)
//   CNT_W      : column step counter width
//   ROW_W      : image row coordinate width
//   PASS_W     : padded-row (pass) counter width; holds 0..IMG_H+3
//   win_state_t: window_ctrl sequencer states
//   win_info_t : window tag travelling alongside the buffer pipeline
// ---------------------------------------------------------------------------
package image_pkg;

    localparam int LINE_DEPTH = 252;
    localparam int PIX_W      = 8;
    localparam int WIN_W      = 24;
    localparam int CNT_W      = 8;
    localparam int ROW_W      = 10;
    localparam int PASS_W     = ROW_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ROW   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } win_state_t;

    typedef struct packed {
        logic             valid;
        logic [ROW_W-1:0] row;
        logic [CNT_W-1:0] col;
        logic [3:0]       edges;  // {top, bottom, left, right}
    } win_info_t;

    // Border markers for a window centred on (row, col).
    function automatic logic [3:0] edge_flags(
        input logic [ROW_W-1:0] row,
        input logic [CNT_W-1:0] col,
        input logic [ROW_W-1:0] row_last,
        input logic [CNT_W-1:0] col_last
    );
        return {row == '0, row == row_last, col == '0, col == col_last};
    endfunction

endpackage

// File: rtl/raster_cnt.sv
// ---------------------------------------------------------------------------
// raster_cnt
//   Column-step / pass counter pair for the window sequencer.  The column
//   counter runs 0..IMG_W; the step that sees cnt==IMG_W wraps it to 0 and
//   advances the pass counter in the same cycle.
//
//   clk, rstn  : clock, asynchronous active-low reset
//   clr        : synchronous clear of both counters
//   step       : advance one column step
//   cnt        : current column step 0..IMG_W
//   pass       : current padded row q
//   col_data   : cnt < IMG_W (a pixel column, not the right border step)
//   col_last   : cnt == IMG_W (next step wraps)
// ---------------------------------------------------------------------------
module raster_cnt
    import image_pkg::*;
#(
    parameter int IMG_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              step,
    output logic [CNT_W-1:0]  cnt,
    output logic [PASS_W-1:0] pass,
    output logic              col_data,
    output logic              col_last
);

    localparam logic [CNT_W-1:0] COL_END = CNT_W'(IMG_W);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            pass <= '0;
        end else if (clr) begin
            cnt  <= '0;
            pass <= '0;
        end else if (step) begin
            if (cnt == COL_END) begin
                cnt  <= '0;
                pass <= pass + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign col_data = (cnt < COL_END);
    assign col_last = (cnt == COL_END);

endmodule

// File: rtl/window_ctrl.sv
// ---------------------------------------------------------------------------
// window_ctrl
//   Sequencer for the 4-line 3x3 window line buffer.  Accepts a raster pixel
//   stream, writes it into the buffer with a zero row above, two zero rows
//   below and a zero column on the right, and tags each valid window with
//   its centre coordinate and border flags.
//
//   Parameters : IMG_W (2..249), IMG_H (1..1023)
//   clk, rstn  : clock, asynchronous active-low reset
//   start      : one-cycle frame start, honoured only in IDLE
//   s_valid    : source pixel valid
//   s_data     : source pixel (raster order)
//   s_ready    : pixel accepted when s_valid && s_ready
//   buf_en     : buffer step enable (registered)
//   buf_data   : byte written into the buffer (registered)
//   buf_pad    : line slot written, padded row mod 4 (registered)
//   buf_cnt    : column step (registered)
//   win_valid  : buffer outputs hold a valid window this cycle
//   win_row    : image row of the window centre
//   win_col    : image column of the window centre
//   win_edge   : {top, bottom, left, right} border flags
//   busy       : frame in progress
//   done       : one-cycle end-of-frame pulse
// ---------------------------------------------------------------------------
module window_ctrl
    import image_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             s_valid,
    input  logic [PIX_W-1:0] s_data,
    output logic             s_ready,
    output logic             buf_en,
    output logic [PIX_W-1:0] buf_data,
    output logic [1:0]       buf_pad,
    output logic [CNT_W-1:0] buf_cnt,
    output logic             win_valid,
    output logic [ROW_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    output logic [3:0]       win_edge,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0]  COL_LAST   = CNT_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [PASS_W-1:0] Q_DATA_END = PASS_W'(IMG_H);
    localparam logic [PASS_W-1:0] Q_END      = PASS_W'(IMG_H + 2);
    localparam logic [PASS_W-1:0] Q_WIN_MIN  = PASS_W'(3);

    win_state_t        state, state_nxt;
    logic              step;
    logic              clr;
    logic [CNT_W-1:0]  cnt;
    logic [PASS_W-1:0] q;
    logic              col_data;
    logic              col_last;
    logic              data_step;
    logic [PASS_W-1:0] q_centre;
    win_info_t         win_now;
    win_info_t         win_s1;

    raster_cnt #(
        .IMG_W (IMG_W)
    ) u_raster_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .step     (step),
        .cnt      (cnt),
        .pass     (q),
        .col_data (col_data),
        .col_last (col_last)
    );

    // Counters are held at zero whenever the sequencer is idle, so a start
    // always begins at q=0, cnt=0.
    assign clr = (state == IDLE);

    // Only ROW data columns consume source pixels; every other step writes 0.
    assign data_step = (state == ROW) && col_data;
    assign s_ready   = data_step;

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = FILL;
            end
            FILL: begin
                step = 1'b1;
                if (col_last) state_nxt = ROW;
            end
            ROW: begin
                // Right-border step runs without waiting on the source.
                step = col_data ? s_valid : 1'b1;
                if (step && col_last && (q == Q_DATA_END)) state_nxt = FLUSH;
            end
            FLUSH: begin
                step = 1'b1;
                if (col_last && (q == Q_END)) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // The window centred on image row q-3 is complete once pass q is being
    // written; its tag rides two register stages to line up with the
    // buffer's registered pixel outputs.
    assign q_centre = q - Q_WIN_MIN;

    always_comb begin
        win_now       = '0;
        win_now.valid = step && (q >= Q_WIN_MIN) && col_data;
        win_now.row   = q_centre[ROW_W-1:0];
        win_now.col   = cnt;
        win_now.edges = edge_flags(q_centre[ROW_W-1:0], cnt, ROW_LAST, COL_LAST);
    end

    // Buffer write stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_en   <= 1'b0;
            buf_data <= '0;
            buf_pad  <= '0;
            buf_cnt  <= '0;
            win_s1   <= '0;
        end else begin
            buf_en <= step;
            win_s1 <= win_now;
            if (step) begin
                buf_data <= data_step ? s_data : '0;
                buf_pad  <= q[1:0];
                buf_cnt  <= cnt;
            end
        end
    end

    // Window tag stage, aligned with the buffer's pixel outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            win_edge  <= '0;
        end else begin
            win_valid <= win_s1.valid;
            win_row   <= win_s1.row;
            win_col   <= win_s1.col;
            win_edge  <= win_s1.edges;
        end
    end

    // done is registered off DONE so it lands one cycle after the last
    // win_valid; busy falls in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (state == DONE);
            if ((state == IDLE) && start) busy <= 1'b1;
            else if (state == DONE)       busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_window_ctrl
//   Self-checking bench for window_ctrl with IMG_W=4, IMG_H=3.  Expected
//   buffer writes and windows are built per frame from the padded-image
//   description and compared in order against what the DUT emits.
// ---------------------------------------------------------------------------
module tb_window_ctrl;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_ready;
    logic       buf_en;
    logic [7:0] buf_data;
    logic [1:0] buf_pad;
    logic [7:0] buf_cnt;
    logic       win_valid;
    logic [9:0] win_row;
    logic [7:0] win_col;
    logic [3:0] win_edge;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    window_ctrl #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .buf_en    (buf_en),
        .buf_data  (buf_data),
        .buf_pad   (buf_pad),
        .buf_cnt   (buf_cnt),
        .win_valid (win_valid),
        .win_row   (win_row),
        .win_col   (win_col),
        .win_edge  (win_edge),
        .busy      (busy),
        .done      (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic [1:0] p;
        logic [7:0] c;
    } bw_t;

    typedef struct {
        int         row;
        int         col;
        logic [3:0] e;
    } wn_t;

    task automatic check_all_zero(input string tag);
        check(tag, 64'({s_ready, buf_en, buf_data, buf_pad, buf_cnt, win_valid,
                        win_row, win_col, win_edge, busy, done}), 64'd0);
    endtask

    // mode 0: s_valid held high; 1: toggling; 2: random with stray starts.
    // rst_at >= 0 pulls rstn low at that cycle of the frame.
    task automatic run_frame(input int mode, input int rst_at);
        logic [7:0] pix[$];
        bw_t        eb[$];
        wn_t        ew[$];
        bw_t        b;
        wn_t        w;
        int         idx = 0;
        int         steps = 0;
        int         wins = 0;
        int         last_win = -10;
        int         first_q3 = -1;
        int         first_win = -1;
        int         done_cyc = -1;
        bit         prev_stall = 0;
        bit         finished = 0;
        bit         aborted = 0;

        for (int i = 0; i < W * H; i++) pix.push_back(8'($urandom_range(1, 255)));
        for (int q = 0; q <= H + 2; q++) begin
            for (int c = 0; c <= W; c++) begin
                b.d = (q >= 1 && q <= H && c < W) ? pix[(q - 1) * W + c] : 8'd0;
                b.p = 2'(q % 4);
                b.c = 8'(c);
                eb.push_back(b);
            end
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                w.row = r;
                w.col = c;
                w.e   = {r == 0, r == H - 1, c == 0, c == W - 1};
                ew.push_back(w);
            end
        end

        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);

        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (buf_en) begin
                if (eb.size() == 0) begin
                    check("extra_buf_step", 64'(buf_en), 64'd0);
                end else begin
                    b = eb.pop_front();
                    check("buf_data", 64'(buf_data), 64'(b.d));
                    check("buf_pad", 64'(buf_pad), 64'(b.p));
                    check("buf_cnt", 64'(buf_cnt), 64'(b.c));
                end
                steps++;
                if (buf_pad == 2'd3 && first_q3 < 0) first_q3 = cyc;
            end
            if (prev_stall) check("stall_no_step", 64'(buf_en), 64'd0);
            if (win_valid) begin
                if (ew.size() == 0) begin
                    check("extra_window", 64'(win_valid), 64'd0);
                end else begin
                    w = ew.pop_front();
                    check("win_row", 64'(win_row), 64'(w.row));
                    check("win_col", 64'(win_col), 64'(w.col));
                    check("win_edge", 64'(win_edge), 64'(w.e));
                end
                wins++;
                last_win = cyc;
                if (first_win < 0) first_win = cyc;
            end
            if (done) begin
                check("done_after_last_win", 64'(cyc), 64'(last_win + 1));
                check("busy_at_done", 64'(busy), 64'd0);
                done_cyc = cyc;
                finished = 1;
            end
            if (cyc == rst_at) begin
                start = 1'b0;
                s_valid = 1'b0;
                #1 rstn = 1'b0;
                #1 check_all_zero("reset_mid_frame");
                @(negedge clk);
                check_all_zero("reset_held");
                rstn = 1'b1;
                aborted = 1;
            end
            if (finished || aborted) break;

            start = 1'b0;
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 2 == 0);
                default: s_valid = ($urandom_range(0, 2) != 0);
            endcase
            if (mode == 2 && $urandom_range(0, 7) == 0) start = 1'b1;
            s_data = (idx < pix.size()) ? pix[idx] : 8'($urandom);
            prev_stall = s_ready && !s_valid;
            if (s_ready && s_valid) idx++;
            @(negedge clk);
        end

        start = 1'b0;
        s_valid = 1'b0;
        if (!aborted) begin
            check("frame_finished", 64'(finished), 64'd1);
            check("step_count", 64'(steps), 64'((H + 3) * (W + 1)));
            check("window_count", 64'(wins), 64'(W * H));
            check("buf_left_over", 64'(eb.size()), 64'd0);
            check("pixels_taken", 64'(idx), 64'(W * H));
            check("first_win_latency", 64'(first_win), 64'(first_q3 + 1));
            if (mode == 0) check("frame_cycles", 64'(done_cyc), 64'((H + 3) * (W + 1) + 1));
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
            check("idle_ready", 64'(s_ready), 64'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset_values");
        rstn = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(2, -1);
        run_frame(0, 12);
        run_frame(0, -1);
        run_frame(2, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
